// File: rtl/out_buf_drain_ctrl.sv
// Output-buffer drain controller: sweeps every compute unit on a chunk-end request, queues the
// words in a small FIFO and streams them out. Optional clamp of negative words: OUT_DRAIN_RELU_EN.
module out_buf_drain_ctrl #(
    parameter int CU_NUM     = 4,
    parameter int DAT_W      = 32,
    parameter int BUF_NUM    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       total_chunk_end_i,
    input  logic [DAT_W-1:0]           out_buf_dat_i,
    output logic [$clog2(CU_NUM)-1:0]  cu_sel_o,
    output logic [$clog2(BUF_NUM)-1:0] acc_buf_sel_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [DAT_W-1:0]           m_data_o,
    output logic [$clog2(CU_NUM)-1:0]  m_cu_idx_o,
    output logic                       m_last_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overflow_err_o
);
    localparam int CU_W  = $clog2(CU_NUM);
    localparam int AB_W  = $clog2(BUF_NUM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DAT_W + CU_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_r, state_nxt_s;
    logic             tce_r;
    logic             req_s, accept_s;
    logic [CU_W-1:0]  cu_sel_r, cu_sel_nxt_s;
    logic [AB_W-1:0]  acc_sel_r, acc_sel_nxt_s;
    logic             busy_r, done_r, done_nxt_s, ovf_r;
    logic [ENT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_s, push_s, pop_s;
    logic [DAT_W-1:0] word_s;
    logic [ENT_W-1:0] head_s;

    // A request landing in the done cycle is treated as arriving while busy.
    assign req_s    = total_chunk_end_i & ~tce_r;
    assign accept_s = req_s & (state_r == ST_IDLE) & ~done_r;

    assign full_s    = (count_r == (PTR_W+1)'(FIFO_DEPTH));
    assign m_valid_o = (count_r != {(PTR_W+1){1'b0}});
    assign pop_s     = m_valid_o & m_ready_i;
    assign head_s    = mem_r[rd_ptr_r];

    assign m_data_o       = head_s[ENT_W-1 -: DAT_W];
    assign m_cu_idx_o     = head_s[CU_W:1];
    assign m_last_o       = head_s[0];
    assign cu_sel_o       = cu_sel_r;
    assign acc_buf_sel_o  = acc_sel_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign overflow_err_o = ovf_r;

    // Word conditioning ahead of the FIFO.
    always_comb begin
`ifdef OUT_DRAIN_RELU_EN
        if (out_buf_dat_i[DAT_W-1]) begin
            word_s = {DAT_W{1'b0}};
        end else begin
            word_s = out_buf_dat_i;
        end
`else
        word_s = out_buf_dat_i;
`endif
    end

    // Sweep FSM next-state and push decision.
    always_comb begin
        state_nxt_s   = state_r;
        cu_sel_nxt_s  = cu_sel_r;
        acc_sel_nxt_s = acc_sel_r;
        done_nxt_s    = 1'b0;
        push_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s  = ST_SWEEP;
                    cu_sel_nxt_s = {CU_W{1'b0}};
                    if (acc_sel_r == AB_W'(BUF_NUM - 1)) begin
                        acc_sel_nxt_s = {AB_W{1'b0}};
                    end else begin
                        acc_sel_nxt_s = acc_sel_r + AB_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (!full_s) begin
                    push_s = 1'b1;
                    if (cu_sel_r == CU_W'(CU_NUM - 1)) begin
                        cu_sel_nxt_s = {CU_W{1'b0}};
                        state_nxt_s  = ST_DRAIN;
                    end else begin
                        cu_sel_nxt_s = cu_sel_r + CU_W'(1);
                    end
                end else begin
                    cu_sel_nxt_s = cu_sel_r;
                end
            end
            ST_DRAIN: begin
                if (pop_s && m_last_o) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM, selects, status flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ST_IDLE;
            tce_r     <= 1'b0;
            cu_sel_r  <= {CU_W{1'b0}};
            acc_sel_r <= {AB_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            tce_r     <= total_chunk_end_i;
            cu_sel_r  <= cu_sel_nxt_s;
            acc_sel_r <= acc_sel_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= done_nxt_s;
            if (req_s && !accept_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Output FIFO; push is gated by the registered full so a simultaneous pop never loses data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {word_s, cu_sel_r, (cu_sel_r == CU_W'(CU_NUM - 1))};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
